fpu_wb_ctrl: RTL
================

FPU_WB_CTRL -- requirements
Module: fpu_wb_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port issue_valid, input, 1: an FP op is offered to the FPU this cycle.
REQ-004 SHALL have port issue_rd, input, 5: destination FP register of the offered op.
REQ-005 SHALL have port issue_lat, input, 3: FPU latency of the offered op (4 add/sub, 5 mul, 6 FMA family).
REQ-006 SHALL have port issue_ready, output, 1: op may be issued; fire = issue_valid & issue_ready.
REQ-007 SHALL have port fpu_result, input, 32: FPU result.
REQ-008 SHALL have port fpu_flags, input, 5: FPU exception flags {NV,DZ,OF,UF,NX}.
REQ-009 SHALL have port fpu_ready, input, 1: FPU completion strobe.
REQ-010 SHALL have port wb_en, output, 1: FP register-file write enable.
REQ-011 SHALL have port wb_rd, output, 5: write address.
REQ-012 SHALL have port wb_data, output, 32: write data.
REQ-013 SHALL have port fflags, output, 5: accumulated exception flags.
REQ-014 SHALL have port fflags_clr, input, 1: clear fflags.
REQ-015 SHALL have port rd_busy, output, 32: one bit per FP register with a write outstanding.
REQ-016 SHALL have port busy, output, 1: any slot or wb stage valid.
REQ-017 SHALL have port err, output, 1: sticky completion-mismatch error.

Function
REQ-018 SHALL hold six completion slots S[0..5], each {valid, rd[4:0]}; S[k] = completion expected k cycles after the current cycle.
REQ-019 SHALL, every edge, shift S[k] <= S[k+1] for k=0..4 and S[5] <= invalid.
REQ-020 SHALL, on fire, write S[issue_lat-1] <= {1, issue_rd}, overriding the shifted value; the op completes exactly issue_lat cycles after the fire cycle.
REQ-021 SHALL drive issue_ready = 1 only when issue_lat is 4..6 and S[issue_lat] is invalid (S[6] always invalid) and rd_busy[issue_rd] = 0; combinational, no dependence on issue_valid.
REQ-022 SHALL, when S[0] valid and fpu_ready = 1, register wb_en <= 1, wb_rd <= S[0].rd, wb_data <= fpu_result at the next edge (writeback one cycle after completion); otherwise wb_en <= 0 and wb_rd/wb_data hold.
REQ-023 SHALL OR fpu_flags into fflags on each matched completion; unmatched completions contribute no flags.
REQ-024 SHALL, when fflags_clr and a matched completion coincide, set fflags <= fpu_flags (clear first, then accumulate).
REQ-025 SHALL set err on any edge where S[0].valid != fpu_ready; err clears only on reset; the S[0] entry is dropped regardless.
REQ-026 SHALL drive rd_busy as OR of decoded rd over valid S[0..5] plus wb_rd when wb_en = 1 (protects until the register-file write).
REQ-027 SHALL accept a fire in the same cycle a matched completion occurs; both take effect at that edge.
REQ-028 SHALL allow issue_rd equal to the rd completing in the current cycle only after its wb_en cycle ends (follows from REQ-026).

Reset
REQ-029 SHALL, with rst_n = 0 at an edge, clear all slots, wb_en, wb_rd, wb_data, fflags and err to 0; outputs busy = 0, rd_busy = 0.
REQ-030 SHALL discard all in-flight entries on reset mid-operation; the FPU shares rst_n, so no stale completions follow.
REQ-031 SHALL ignore issue_valid, fpu_ready and fflags_clr while rst_n = 0.

Verification
REQ-032 SHALL cover: fire FADD rd=3, lat=4 at cycle 0; fpu_ready with result 0x40400000, flags 0x01 at cycle 4 -> wb_en=1, wb_rd=3, wb_data=0x40400000 in cycle 5; fflags=0x01; err=0.
REQ-033 SHALL cover: fire FMADD lat=6 rd=1 at cycle 0, then offer FADD lat=4 rd=2 at cycle 2 -> issue_ready=0 (S[4] occupied); same offer at cycle 3 -> accepted.
REQ-034 SHALL cover: rd=7 outstanding, offer new op rd=7 -> issue_ready=0 until the cycle after wb_en for rd=7 deasserts.
REQ-035 SHALL cover: fpu_ready=1 with no slot valid -> err=1 next cycle, wb_en=0, fflags unchanged; err persists until rst_n=0.
REQ-036 SHALL cover: fflags=0x04, fflags_clr with matched completion flags 0x02 -> fflags=0x02.
REQ-037 SHALL cover: three ops in flight, rst_n=0 for one edge -> busy=0, rd_busy=0, fflags=0, no wb_en afterwards.

Source files
------------

// File: rtl/fpu_wb_ctrl.sv
// FPU writeback controller: tracks in-flight FP ops in a completion-slot shift register,
// gates issue on writeback-port and destination-register conflicts, and accumulates fflags.
module fpu_wb_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [2:0]  issue_lat,
  output logic        issue_ready,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  input  logic        fpu_ready,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic [31:0] rd_busy,
  output logic        busy,
  output logic        err
);

  localparam int unsigned NumSlots = 6;

  logic [NumSlots-1:0] slot_valid_q, slot_valid_d;
  logic [4:0]          slot_rd_q [NumSlots];
  logic [4:0]          slot_rd_d [NumSlots];
  logic                wb_en_q, wb_en_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [4:0]          fflags_q, fflags_d;
  logic                err_q, err_d;

  logic       lat_free;
  logic       fire;
  logic       matched;
  logic [2:0] slot_idx;

  // The slot that will shift into S[lat-1] at this edge must be empty.
  always_comb begin
    lat_free = 1'b0;
    case (issue_lat)
      3'd4:    lat_free = ~slot_valid_q[4];
      3'd5:    lat_free = ~slot_valid_q[5];
      3'd6:    lat_free = 1'b1;
      default: lat_free = 1'b0;
    endcase
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NumSlots; k++) begin
      if (slot_valid_q[k]) rd_busy[slot_rd_q[k]] = 1'b1;
    end
    // Keep the register reserved until the register-file write has happened.
    if (wb_en_q) rd_busy[wb_rd_q] = 1'b1;
  end

  assign issue_ready = lat_free & ~rd_busy[issue_rd];
  assign fire        = issue_valid & issue_ready;
  assign matched     = slot_valid_q[0] & fpu_ready;
  assign slot_idx    = issue_lat - 3'd1;

  always_comb begin
    slot_valid_d = {1'b0, slot_valid_q[NumSlots-1:1]};
    for (int k = 0; k < NumSlots - 1; k++) begin
      slot_rd_d[k] = slot_rd_q[k+1];
    end
    slot_rd_d[NumSlots-1] = '0;
    if (fire) begin
      slot_valid_d[slot_idx] = 1'b1;
      slot_rd_d[slot_idx]    = issue_rd;
    end

    wb_en_d   = matched;
    wb_rd_d   = matched ? slot_rd_q[0] : wb_rd_q;
    wb_data_d = matched ? fpu_result   : wb_data_q;

    // Clear takes effect before accumulating a coincident completion.
    if (fflags_clr) begin
      fflags_d = matched ? fpu_flags : 5'd0;
    end else begin
      fflags_d = matched ? (fflags_q | fpu_flags) : fflags_q;
    end

    err_d = err_q | (slot_valid_q[0] != fpu_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      slot_rd_q    <= '{default: '0};
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      fflags_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_rd_q    <= slot_rd_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      fflags_q     <= fflags_d;
      err_q        <= err_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign fflags  = fflags_q;
  assign err     = err_q;
  assign busy    = (|slot_valid_q) | wb_en_q;

endmodule
